// File: rtl/fifo_stream_reader_if.sv
// Signal bundle between fifo_stream_reader (master) and its FIFO/consumer side (slave).
// Stream handshake: a word moves on a rising edge where out_valid && out_ready; once
// out_valid is high, out_data/out_last hold until that edge. fifo_data is valid the
// cycle after fifo_rd_en was high.
interface fifo_stream_reader_if #(
  parameter int WIDTH = 16
);
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic [1:0]       dbg_occ;
  logic             dbg_pend;
  logic             dbg_state;

  modport master (
    input  fifo_empty, fifo_data, out_ready,
    output fifo_rd_en, out_valid, out_data, out_last, dbg_occ, dbg_pend, dbg_state
  );

  modport slave (
    output fifo_empty, fifo_data, out_ready,
    input  fifo_rd_en, out_valid, out_data, out_last, dbg_occ, dbg_pend, dbg_state
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// FIFO drain stage: absorbs the one-cycle FIFO read latency into a 2-entry skid buffer.
// Define FIFO_RD_FRAME_EN to strip length headers and flag the last payload word.
module fifo_stream_reader #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 8
) (
  input  logic                 clock,
  input  logic                 rst,
  fifo_stream_reader_if.master bus
);

  if (LEN_W < 1 || LEN_W > WIDTH) begin : g_len_w_check
    $error("fifo_stream_reader: LEN_W must be in 1..WIDTH");
  end

  logic [WIDTH-1:0] r_buf [2];
  logic             r_head;
  logic             r_tail;
  logic [1:0]       r_occ;
  logic             r_pend;

  logic [WIDTH-1:0] w_head_word;
  logic             w_out_pop;
  logic             w_hdr_pop;
  logic             w_pop;
  logic [2:0]       w_level;
  logic             w_rd_en;

  assign w_head_word = r_buf[r_head];
  assign w_out_pop   = bus.out_valid && bus.out_ready;
  assign w_pop       = w_out_pop || w_hdr_pop;

  // Slots committed after this cycle: buffered + in flight - leaving now.
  assign w_level = {1'b0, r_occ} + {2'b00, r_pend} - {2'b00, w_pop};
  assign w_rd_en = rst && !bus.fifo_empty && (w_level < 3'd2);

  assign bus.fifo_rd_en = w_rd_en;
  assign bus.out_data   = w_head_word;
  assign bus.dbg_occ    = r_occ;
  assign bus.dbg_pend   = r_pend;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_buf[0] <= '0;
      r_buf[1] <= '0;
      r_head   <= 1'b0;
      r_tail   <= 1'b0;
      r_occ    <= 2'd0;
      r_pend   <= 1'b0;
    end else begin
      r_pend <= w_rd_en;
      if (r_pend) begin
        r_buf[r_tail] <= bus.fifo_data;
        r_tail        <= ~r_tail;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      r_occ <= r_occ + {1'b0, r_pend} - {1'b0, w_pop};
    end
  end

`ifdef FIFO_RD_FRAME_EN
  typedef enum logic {
    ST_HDR = 1'b0,
    ST_PAY = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [LEN_W-1:0] r_rem;
  logic [LEN_W-1:0] w_rem_nxt;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_state <= ST_HDR;
      r_rem   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_hdr_pop   = 1'b0;
    case (r_state)
      ST_HDR: begin
        // A zero-length header is swallowed and the next head word is another header.
        if (r_occ != 2'd0) begin
          w_hdr_pop = 1'b1;
          w_rem_nxt = w_head_word[LEN_W-1:0];
          if (w_head_word[LEN_W-1:0] != '0) begin
            w_state_nxt = ST_PAY;
          end
        end
      end
      ST_PAY: begin
        if (w_out_pop) begin
          w_rem_nxt = r_rem - LEN_W'(1);
          if (r_rem == LEN_W'(1)) begin
            w_state_nxt = ST_HDR;
          end
        end
      end
      default: w_state_nxt = ST_HDR;
    endcase
  end

  assign bus.out_valid = (r_occ != 2'd0) && (r_state == ST_PAY);
  assign bus.out_last  = (r_state == ST_PAY) && (r_rem == LEN_W'(1));
  assign bus.dbg_state = (r_state == ST_PAY);
`else
  assign w_hdr_pop     = 1'b0;
  assign bus.out_valid = (r_occ != 2'd0);
  assign bus.out_last  = 1'b0;
  assign bus.dbg_state = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FIFO, stream model and scoreboard.
// Build with FIFO_RD_FRAME_EN defined to exercise header framing.
`timescale 1ns/1ps
module tb_fifo_stream_reader;
  localparam int WIDTH = 16;
  localparam int LEN_W = 8;

  logic clock = 1'b0;
  logic rst   = 1'b0;
  always #5 clock = ~clock;

  fifo_stream_reader_if #(.WIDTH(WIDTH)) bus ();

  fifo_stream_reader #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Behavioural FIFO: words staged by the bench enter at the next rising edge.
  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] stage_q[$];
  always @(posedge clock or negedge rst) begin
    if (!rst) begin
      fifo_q.delete();
      bus.fifo_data  <= '0;
      bus.fifo_empty <= 1'b1;
    end else begin
      if (bus.fifo_rd_en && fifo_q.size() != 0) bus.fifo_data <= fifo_q.pop_front();
      while (stage_q.size() != 0) fifo_q.push_back(stage_q.pop_front());
      bus.fifo_empty <= (fifo_q.size() == 0);
    end
  end

  // Monitor: mid-cycle sampling of the handshake that completes at the next edge.
  logic [WIDTH-1:0] rx_data[$];
  logic             rx_last[$];
  int               rd_count   = 0;
  int               empty_viol = 0;
  int               occ_viol   = 0;
  int               stall_viol = 0;
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data  = '0;
  logic             prev_last  = 1'b0;
  always @(negedge clock) begin
    if (rst) begin
      if (bus.fifo_rd_en) rd_count <= rd_count + 1;
      if (bus.fifo_rd_en && bus.fifo_empty) empty_viol <= empty_viol + 1;
      if ({1'b0, bus.dbg_occ} + {2'b00, bus.dbg_pend} > 3'd2) occ_viol <= occ_viol + 1;
      if (prev_stall && (bus.out_valid !== 1'b1 || bus.out_data !== prev_data || bus.out_last !== prev_last))
        stall_viol <= stall_viol + 1;
      if (bus.out_valid && bus.out_ready) begin
        rx_data.push_back(bus.out_data);
        rx_last.push_back(bus.out_last);
      end
      prev_stall <= bus.out_valid && !bus.out_ready;
      prev_data  <= bus.out_data;
      prev_last  <= bus.out_last;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  // Expected stream, derived from the list of FIFO words.
  logic [WIDTH-1:0] exp_q[$];
  logic             exp_last_q[$];

  task automatic model_stream(input logic [WIDTH-1:0] words[$]);
`ifdef FIFO_RD_FRAME_EN
    int i = 0;
    while (i < words.size()) begin
      int len = int'(words[i][LEN_W-1:0]);
      i++;
      for (int k = 0; k < len && i < words.size(); k++) begin
        exp_q.push_back(words[i]);
        exp_last_q.push_back(k == len - 1);
        i++;
      end
    end
`else
    foreach (words[j]) begin
      exp_q.push_back(words[j]);
      exp_last_q.push_back(1'b0);
    end
`endif
  endtask

  // Wrap a payload into the stream format of this build (one frame when framing).
  task automatic frame_words(input logic [WIDTH-1:0] payload[$], output logic [WIDTH-1:0] words[$]);
    words = payload;
`ifdef FIFO_RD_FRAME_EN
    words.push_front(WIDTH'(payload.size()));
`endif
  endtask

  task automatic clear_sb();
    exp_q.delete();
    exp_last_q.delete();
    rx_data.delete();
    rx_last.delete();
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_all(input logic [WIDTH-1:0] words[$]);
    foreach (words[j]) stage_q.push_back(words[j]);
  endtask

  task automatic drain(input int budget, output bit timed_out);
    int n = 0;
    bus.out_ready = 1'b1;
    while (rx_data.size() < exp_q.size() && n < budget) begin
      tick();
      n++;
    end
    timed_out = (rx_data.size() < exp_q.size());
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    checks++; if (bus.fifo_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b exp=0", bus.fifo_rd_en); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0000", bus.out_data); end
    checks++; if (bus.out_last !== 1'b0) begin failures++; $display("FAIL reset_last got=%b exp=0", bus.out_last); end
    checks++; if (bus.dbg_occ !== 2'd0) begin failures++; $display("FAIL reset_occ got=%0d exp=0", bus.dbg_occ); end
    checks++; if (bus.dbg_pend !== 1'b0) begin failures++; $display("FAIL reset_pend got=%b exp=0", bus.dbg_pend); end
    checks++; if (bus.dbg_state !== 1'b0) begin failures++; $display("FAIL reset_state got=%b exp=0", bus.dbg_state); end
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (bus.fifo_rd_en !== 1'b0) begin failures++; $display("FAIL idle_rd_en got=%b exp=0", bus.fifo_rd_en); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL idle_valid got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_latency();
    logic [WIDTH-1:0] payload[$] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    logic [WIDTH-1:0] words[$];
    int lat;
    int e0 = empty_viol;
`ifdef FIFO_RD_FRAME_EN
    lat = 3;
`else
    lat = 2;
`endif
    clear_sb();
    frame_words(payload, words);
    model_stream(words);
    bus.out_ready = 1'b1;
    push_all(words);
    tick();
    for (int c = 0; c <= lat + 3; c++) begin
      @(negedge clock);
      if (c == 0) begin
        checks++; if (bus.fifo_rd_en !== 1'b1) begin failures++; $display("FAIL lat_rd_en got=%b exp=1", bus.fifo_rd_en); end
      end
      checks++;
      if (bus.out_valid !== (c >= lat)) begin
        failures++; $display("FAIL lat_valid cycle=%0d got=%b exp=%b", c, bus.out_valid, c >= lat);
      end else if (c >= lat) begin
        checks++;
        if (bus.out_data !== exp_q[c-lat] || bus.out_last !== exp_last_q[c-lat]) begin
          failures++;
          $display("FAIL lat_word cycle=%0d got=%h/%b exp=%h/%b", c, bus.out_data, bus.out_last, exp_q[c-lat], exp_last_q[c-lat]);
        end
      end
    end
    @(negedge clock);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL lat_end_valid got=%b exp=0", bus.out_valid); end
    tick();
    checks++; if (empty_viol !== e0) begin failures++; $display("FAIL lat_rd_while_empty got=%0d exp=%0d", empty_viol, e0); end
  endtask

  task automatic test_toggle();
    logic [WIDTH-1:0] payload[$];
    logic [WIDTH-1:0] words[$];
    int s0 = stall_viol;
    int o0 = occ_viol;
    clear_sb();
    for (int i = 0; i < 8; i++) payload.push_back(WIDTH'($urandom));
    frame_words(payload, words);
    model_stream(words);
    push_all(words);
    for (int cyc = 0; cyc < 300 && rx_data.size() < exp_q.size(); cyc++) begin
      bus.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      tick();
    end
    bus.out_ready = 1'b1;
    repeat (4) tick();
    checks++; if (rx_data.size() != exp_q.size()) begin failures++; $display("FAIL toggle_count got=%0d exp=%0d", rx_data.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_data.size(); i++) begin
      checks++;
      if (rx_data[i] !== exp_q[i] || rx_last[i] !== exp_last_q[i]) begin
        failures++; $display("FAIL toggle_word idx=%0d got=%h/%b exp=%h/%b", i, rx_data[i], rx_last[i], exp_q[i], exp_last_q[i]);
      end
    end
    checks++; if (stall_viol !== s0) begin failures++; $display("FAIL toggle_stall_stable got=%0d exp=%0d", stall_viol, s0); end
    checks++; if (occ_viol !== o0) begin failures++; $display("FAIL toggle_occ_pend got=%0d exp=%0d", occ_viol, o0); end
  endtask

  task automatic test_stall();
    logic [WIDTH-1:0] payload[$];
    logic [WIDTH-1:0] words[$];
    int r0;
    int exp_reads;
    bit to;
`ifdef FIFO_RD_FRAME_EN
    exp_reads = 3;
`else
    exp_reads = 2;
`endif
    clear_sb();
    for (int i = 0; i < 5; i++) payload.push_back(WIDTH'($urandom));
    frame_words(payload, words);
    model_stream(words);
    bus.out_ready = 1'b0;
    r0 = rd_count;
    push_all(words);
    repeat (12) tick();
    @(negedge clock);
    checks++; if (rd_count - r0 != exp_reads) begin failures++; $display("FAIL stall_reads got=%0d exp=%0d", rd_count - r0, exp_reads); end
    checks++; if (bus.fifo_rd_en !== 1'b0) begin failures++; $display("FAIL stall_rd_en got=%b exp=0", bus.fifo_rd_en); end
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_q[0]) begin
      failures++; $display("FAIL stall_head got=%b/%h exp=1/%h", bus.out_valid, bus.out_data, exp_q[0]);
    end
    @(posedge clock); #1;
    bus.out_ready = 1'b1;
    @(negedge clock);
    checks++; if (bus.fifo_rd_en !== 1'b1) begin failures++; $display("FAIL stall_release_rd_en got=%b exp=1", bus.fifo_rd_en); end
    drain(100, to);
    checks++; if (to) begin failures++; $display("FAIL stall_drain_timeout got=%0d exp=%0d", rx_data.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_data.size(); i++) begin
      checks++;
      if (rx_data[i] !== exp_q[i] || rx_last[i] !== exp_last_q[i]) begin
        failures++; $display("FAIL stall_word idx=%0d got=%h/%b exp=%h/%b", i, rx_data[i], rx_last[i], exp_q[i], exp_last_q[i]);
      end
    end
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] payload[$];
    logic [WIDTH-1:0] words[$];
    bit to;
    clear_sb();
    for (int i = 0; i < 3; i++) payload.push_back(WIDTH'($urandom));
    frame_words(payload, words);
    bus.out_ready = 1'b0;
    push_all(words);
    repeat (3) tick();
    @(negedge clock);
    checks++; if (bus.dbg_occ !== 2'd1 || bus.dbg_pend !== 1'b1) begin
      failures++; $display("FAIL mid_pre_state got=occ%0d/pend%b exp=occ1/pend1", bus.dbg_occ, bus.dbg_pend);
    end
    #2;
    rst = 1'b0;
    stage_q.delete();
    #1;
    checks++; if (bus.fifo_rd_en !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_last !== 1'b0) begin
      failures++;
      $display("FAIL mid_async_outputs got=rd%b/v%b/d%h/l%b exp=rd0/v0/d0000/l0", bus.fifo_rd_en, bus.out_valid, bus.out_data, bus.out_last);
    end
    checks++; if (bus.dbg_occ !== 2'd0 || bus.dbg_pend !== 1'b0) begin
      failures++; $display("FAIL mid_async_state got=occ%0d/pend%b exp=occ0/pend0", bus.dbg_occ, bus.dbg_pend);
    end
    @(negedge clock);
    tick();
    rst = 1'b1;
    clear_sb();
    payload.delete();
    for (int i = 0; i < 4; i++) payload.push_back(WIDTH'($urandom));
    frame_words(payload, words);
    model_stream(words);
    push_all(words);
    drain(100, to);
    repeat (4) tick();
    checks++; if (to || rx_data.size() != exp_q.size()) begin
      failures++; $display("FAIL mid_resume_count got=%0d exp=%0d", rx_data.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_data.size(); i++) begin
      checks++;
      if (rx_data[i] !== exp_q[i]) begin failures++; $display("FAIL mid_resume_word idx=%0d got=%h exp=%h", i, rx_data[i], exp_q[i]); end
    end
  endtask

  task automatic test_frame();
    logic [WIDTH-1:0] words[$] = '{16'h0003, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'h0000, 16'h0001, 16'hDDDD};
`ifdef FIFO_RD_FRAME_EN
    logic [WIDTH-1:0] tab_d[$] = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
    logic             tab_l[$] = '{1'b0, 1'b0, 1'b1, 1'b1};
`else
    logic [WIDTH-1:0] tab_d[$] = '{16'h0003, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'h0000, 16'h0001, 16'hDDDD};
    logic             tab_l[$] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    bit to;
    clear_sb();
    exp_q = tab_d;
    exp_last_q = tab_l;
    push_all(words);
    drain(100, to);
    repeat (4) tick();
    checks++; if (to || rx_data.size() != tab_d.size()) begin
      failures++; $display("FAIL frame_count got=%0d exp=%0d", rx_data.size(), tab_d.size());
    end
    for (int i = 0; i < tab_d.size() && i < rx_data.size(); i++) begin
      checks++;
      if (rx_data[i] !== tab_d[i] || rx_last[i] !== tab_l[i]) begin
        failures++; $display("FAIL frame_word idx=%0d got=%h/%b exp=%h/%b", i, rx_data[i], rx_last[i], tab_d[i], tab_l[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int round = 0; round < 4; round++) begin
      logic [WIDTH-1:0] words[$];
      int ptr = 0;
      int s0 = stall_viol;
      int o0 = occ_viol;
      int e0 = empty_viol;
      clear_sb();
`ifdef FIFO_RD_FRAME_EN
      for (int f = 0; f < int'($urandom_range(3, 6)); f++) begin
        logic [WIDTH-1:0] hdr = WIDTH'($urandom);
        int len = int'($urandom_range(0, 5));
        hdr[LEN_W-1:0] = LEN_W'(len);
        words.push_back(hdr);
        for (int k = 0; k < len; k++) words.push_back(WIDTH'($urandom));
      end
`else
      for (int k = 0; k < int'($urandom_range(10, 30)); k++) words.push_back(WIDTH'($urandom));
`endif
      model_stream(words);
      for (int cyc = 0; cyc < 2000 && (rx_data.size() < exp_q.size() || ptr < words.size()); cyc++) begin
        if (ptr < words.size() && $urandom_range(0, 1) == 1) begin
          for (int n = int'($urandom_range(1, 3)); n > 0 && ptr < words.size(); n--) begin
            stage_q.push_back(words[ptr]);
            ptr++;
          end
        end
        bus.out_ready = ($urandom_range(0, 3) != 0);
        tick();
      end
      bus.out_ready = 1'b1;
      repeat (4) tick();
      checks++; if (rx_data.size() != exp_q.size()) begin
        failures++; $display("FAIL rand_count round=%0d got=%0d exp=%0d", round, rx_data.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < rx_data.size(); i++) begin
        checks++;
        if (rx_data[i] !== exp_q[i] || rx_last[i] !== exp_last_q[i]) begin
          failures++;
          $display("FAIL rand_word round=%0d idx=%0d got=%h/%b exp=%h/%b", round, i, rx_data[i], rx_last[i], exp_q[i], exp_last_q[i]);
        end
      end
      checks++; if (stall_viol !== s0 || occ_viol !== o0 || empty_viol !== e0) begin
        failures++;
        $display("FAIL rand_rules round=%0d got=stall%0d/occ%0d/empty%0d exp=%0d/%0d/%0d", round, stall_viol, occ_viol, empty_viol, s0, o0, e0);
      end
    end
  endtask

  initial begin
    bus.out_ready = 1'b0;
    test_reset();
    test_latency();
    test_toggle();
    test_stall();
    test_reset_mid();
    test_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Downstream drain stage for the synchronous FIFO. Issues FIFO reads, absorbs the FIFO's one-cycle registered read latency, and presents the words on a valid/ready stream with a 2-entry buffer so the consumer may stall at any time without losing data. Sustains one word per cycle when the FIFO is non-empty and the consumer is ready. Optionally parses length-header framing and marks the last word of each frame.

## Interface
- `WIDTH`, 16: data width; must match the FIFO's `WIDTH`.
- `LEN_W`, 8: width of the frame length field, taken from header bits `[LEN_W-1:0]`; must satisfy `LEN_W <= WIDTH`. Used only under `FIFO_RD_FRAME_EN`.
- `clock`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous active-low reset (one clock; reset is asynchronous and active-low).
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rd_en`  out  1  FIFO read enable; combinational.
- `fifo_data`  in  WIDTH  FIFO `data_out`; valid the cycle after an accepted read.
- `out_valid`  out  1  stream word available; registered.
- `out_ready`  in  1  consumer accepts the word this cycle.
- `out_data`  out  WIDTH  stream word; registered, stable while `out_valid && !out_ready`.
- `out_last`  out  1  last word of a frame; registered; constant 0 without `FIFO_RD_FRAME_EN`.

## Operation
- State:
  - 2-entry output buffer (`occ` = 0..2) with head/tail indices that wrap modulo 2.
  - `pend` flag marking a FIFO read issued in the previous cycle.
- Pop: `pop = out_valid && out_ready`, or an internal header consume (framing only).
- Read issue: `fifo_rd_en = !fifo_empty && (occ + pend - pop) < 2`. Both `pop` terms are same-cycle values, so the path from `out_ready` to `fifo_rd_en` is combinational.
- Next-cycle `pend` = `fifo_rd_en`.
- When `pend` is 1, `fifo_data` is written at tail. Push and pop in the same cycle leave `occ` unchanged.
- `occ + pend` never exceeds 2. The buffer never overflows, so no read is ever dropped.
- `out_valid` = `occ != 0` (and head is not a header word under framing). `out_data` = buffer head.
- Framing state machine, with `FIFO_RD_FRAME_EN`:
  - `HDR` to `PAY`: head word is consumed internally (never output) and `rem` is loaded with `header[LEN_W-1:0]`. If that field is 0, the header is dropped and the state stays `HDR`.
  - `PAY`: each output pop decrements `rem`. `out_last` = (`rem == 1`). A pop with `rem == 1` returns the state to `HDR`.
  - A header consume takes one cycle and counts as a pop for read issue.

## Timing
- Reset (async assert; deassert is synchronised externally):
  - Outputs: `fifo_rd_en` 0 (forced while `rst` is low), `out_valid` 0, `out_data` 0, `out_last` 0.
  - State: `occ` 0, `pend` 0, state `HDR`, `rem` 0.
- Latency: `fifo_empty` falls in cycle N → `fifo_rd_en` is 1 in N → `fifo_data` is valid in N+1 and captured at the end of N+1 → `out_valid` is 1 in N+2.
- Throughput: with `out_ready` held at 1 and the FIFO non-empty, one word per cycle, with no bubbles after the first.
- Stall: with `out_ready` at 0, at most 2 reads complete and then `fifo_rd_en` stays 0. When `out_ready` returns, `fifo_rd_en` reasserts in the same cycle.
- Stream rule: once `out_valid` is asserted it stays high, with `out_data` and `out_last` unchanged, until accepted.
- Empty: `fifo_rd_en` is never asserted while `fifo_empty` is 1.
- Reset mid-operation discards the buffered words and any in-flight read. The FIFO shares the reset, so no word is duplicated.

## Configuration
- `FIFO_RD_FRAME_EN` defined: the `HDR`/`PAY` framing state machine and `rem` counter are compiled in, headers are stripped, and `out_last` marks the final payload word.
- `FIFO_RD_FRAME_EN` undefined: every FIFO word passes through unchanged, `out_last` is tied to 0, and the framing logic is absent.

## Test plan
- Reset, then push 0x0001..0x0004 into the FIFO with `out_ready` at 1:
  - `out_valid` rises 2 cycles after `fifo_empty` falls.
  - Words 0x0001..0x0004 appear on 4 consecutive cycles.
  - `fifo_rd_en` is never high while the FIFO is empty.
- FIFO holds 8 words and `out_ready` toggles 1,0,0,1,... :
  - All 8 words are delivered in order with none lost or duplicated.
  - `out_data` is stable through every stall.
  - `occ + pend` is never greater than 2.
- `out_ready` held at 0 with 5 words queued: exactly 2 reads are issued and `fifo_rd_en` then stays 0; releasing `out_ready` drains all 5 words.
- `rst` is pulsed low mid-stream with 1 word buffered and 1 read pending: all outputs are 0 asynchronously, and after release the stream resumes cleanly from new FIFO contents.
- With `FIFO_RD_FRAME_EN`, FIFO holds 0x0003, 0xAAAA, 0xBBBB, 0xCCCC, 0x0000, 0x0001, 0xDDDD:
  - Output is 0xAAAA, 0xBBBB, 0xCCCC (`out_last` on 0xCCCC), then 0xDDDD (`out_last` on 0xDDDD).
  - Headers and the zero-length header never appear on the output.
- Without `FIFO_RD_FRAME_EN`, the same 7 words pass through unchanged and `out_last` is 0 throughout.
